// File: rtl/vga_sync_gen_if.sv
// ---------------------------------------------------------------------------
// vga_sync_gen_if
//   Bundles the pixel clock enable and the timing outputs of vga_sync_gen
//   into one connection.
//
//   Signals
//     pix_ce       pixel clock enable into the generator
//     hsync        horizontal sync to the connector
//     vsync        vertical sync to the connector
//     video_on     high inside the visible 640x480 window
//     s_pixel_col  raw horizontal count
//     s_pixel_row  raw vertical count
//     line_start   one-cycle strobe at the first pixel of every line
//     frame_start  one-cycle strobe at the first pixel of every frame
//
//   Modports
//     master  the timing generator (drives the timing, receives pix_ce)
//     slave   a downstream consumer (drives pix_ce, receives the timing)
// ---------------------------------------------------------------------------
interface vga_sync_gen_if;

  logic       pix_ce;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [9:0] s_pixel_col;
  logic [9:0] s_pixel_row;
  logic       line_start;
  logic       frame_start;

  modport master (
    input  pix_ce,
    output hsync,
    output vsync,
    output video_on,
    output s_pixel_col,
    output s_pixel_row,
    output line_start,
    output frame_start
  );

  modport slave (
    output pix_ce,
    input  hsync,
    input  vsync,
    input  video_on,
    input  s_pixel_col,
    input  s_pixel_row,
    input  line_start,
    input  frame_start
  );

endinterface

// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen
//   Free-running 640x480@60Hz VGA timing generator on the 25 MHz pixel clock.
//   Produces hsync/vsync for the connector, raw pixel row/column and a
//   video_on window for the image path, plus line/frame start strobes.
//
//   Ports
//     clk_25   in   25 MHz pixel clock, sole clock
//     reset    in   synchronous, active-high reset
//     bus      vga_sync_gen_if.master
//                pix_ce (in), hsync, vsync, video_on, s_pixel_col,
//                s_pixel_row, line_start, frame_start (out)
//
//   Build option
//     VGA_SYNC_REG_EN  when defined, every output passes through one register
//                      stage (all outputs lag the counters by one clk_25 and
//                      stay mutually aligned). When undefined, outputs are
//                      decoded combinationally from the counters.
//
//   H_TOTAL and V_TOTAL must both be <= 1024 (10-bit counters).
// ---------------------------------------------------------------------------
module vga_sync_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned SYNC_POL = 0
) (
  input  logic           clk_25,
  input  logic           reset,
  vga_sync_gen_if.master bus
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // Window bounds are 11 bits so an end bound of exactly 1024 still compares
  // correctly against the 10-bit counters.
  localparam logic [10:0] H_VIS_END = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_VIS_END = 11'(V_ACTIVE);
  localparam logic [10:0] VS_START  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic SYNC_ON  = (SYNC_POL != 0);
  localparam logic SYNC_OFF = ~SYNC_ON;

  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic [10:0] h_ext;
  logic [10:0] v_ext;

  logic       dec_hsync;
  logic       dec_vsync;
  logic       dec_video_on;
  logic       dec_line_start;
  logic       dec_frame_start;
  logic [9:0] dec_col;
  logic [9:0] dec_row;

  assign h_ext = {1'b0, h_cnt};
  assign v_ext = {1'b0, v_cnt};

  // ------------------------------------------------------------------------
  // Raster counters: the vertical count only moves on the horizontal wrap.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk_25) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (bus.pix_ce) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        if (v_cnt == V_LAST) begin
          v_cnt <= '0;
        end else begin
          v_cnt <= v_cnt + 10'd1;
        end
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // ------------------------------------------------------------------------
  // Timing decode. While reset is asserted every output shows its inactive
  // value (row/col at 0), so the unregistered and registered builds differ
  // by exactly one clock even across a mid-frame reset.
  // ------------------------------------------------------------------------
  always_comb begin
    dec_hsync       = SYNC_OFF;
    dec_vsync       = SYNC_OFF;
    dec_video_on    = 1'b0;
    dec_line_start  = 1'b0;
    dec_frame_start = 1'b0;
    dec_col         = '0;
    dec_row         = '0;
    if (!reset) begin
      if (h_ext >= HS_START && h_ext < HS_END) begin
        dec_hsync = SYNC_ON;
      end
      if (v_ext >= VS_START && v_ext < VS_END) begin
        dec_vsync = SYNC_ON;
      end
      dec_video_on    = (h_ext < H_VIS_END) && (v_ext < V_VIS_END);
      dec_line_start  = bus.pix_ce && (h_cnt == '0);
      dec_frame_start = bus.pix_ce && (h_cnt == '0) && (v_cnt == '0);
      dec_col         = h_cnt;
      dec_row         = v_cnt;
    end
  end

`ifdef VGA_SYNC_REG_EN
  // ------------------------------------------------------------------------
  // Output register stage: loads the decode every clock so that the whole
  // output set is the unregistered output set delayed by one clk_25.
  // ------------------------------------------------------------------------
  logic       hsync_q;
  logic       vsync_q;
  logic       video_on_q;
  logic       line_start_q;
  logic       frame_start_q;
  logic [9:0] col_q;
  logic [9:0] row_q;

  always_ff @(posedge clk_25) begin
    if (reset) begin
      hsync_q       <= SYNC_OFF;
      vsync_q       <= SYNC_OFF;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      col_q         <= '0;
      row_q         <= '0;
    end else begin
      hsync_q       <= dec_hsync;
      vsync_q       <= dec_vsync;
      video_on_q    <= dec_video_on;
      line_start_q  <= dec_line_start;
      frame_start_q <= dec_frame_start;
      col_q         <= dec_col;
      row_q         <= dec_row;
    end
  end

  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.video_on    = video_on_q;
  assign bus.line_start  = line_start_q;
  assign bus.frame_start = frame_start_q;
  assign bus.s_pixel_col = col_q;
  assign bus.s_pixel_row = row_q;
`else
  assign bus.hsync       = dec_hsync;
  assign bus.vsync       = dec_vsync;
  assign bus.video_on    = dec_video_on;
  assign bus.line_start  = dec_line_start;
  assign bus.frame_start = dec_frame_start;
  assign bus.s_pixel_col = dec_col;
  assign bus.s_pixel_row = dec_row;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_gen
//   Drives two vga_sync_gen instances with the same clock, reset and pix_ce:
//   one with the standard 640x480 timing (active-low sync) and one with a
//   tiny raster and active-high sync so that whole frames and vsync fit in
//   a short run. Expected outputs come from a linear pixel-position model:
//   position p counts pixels since frame start, col = p % H_TOTAL and
//   row = p / H_TOTAL. With VGA_SYNC_REG_EN defined the expectation is the
//   previous cycle's value.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_sync_gen;

  // Small raster: 32 clocks per line, 17 lines per frame.
  localparam int unsigned S_HA = 20, S_HFP = 3, S_HS = 5, S_HBP = 4;
  localparam int unsigned S_VA = 10, S_VFP = 2, S_VS = 2, S_VBP = 3;
  localparam int unsigned S_HT = S_HA + S_HFP + S_HS + S_HBP;
  localparam int unsigned S_VT = S_VA + S_VFP + S_VS + S_VBP;

  localparam int unsigned D_HT = 800;
  localparam int unsigned D_VT = 525;

  logic clk_25 = 1'b0;
  logic reset  = 1'b1;
  logic ce     = 1'b1;

  always #20 clk_25 = ~clk_25;

  vga_sync_gen_if bus_d ();
  vga_sync_gen_if bus_s ();

  assign bus_d.pix_ce = ce;
  assign bus_s.pix_ce = ce;

  vga_sync_gen dut_d (
    .clk_25 (clk_25),
    .reset  (reset),
    .bus    (bus_d)
  );

  vga_sync_gen #(
    .H_ACTIVE (S_HA),
    .H_FP     (S_HFP),
    .H_SYNC   (S_HS),
    .H_BP     (S_HBP),
    .V_ACTIVE (S_VA),
    .V_FP     (S_VFP),
    .V_SYNC   (S_VS),
    .V_BP     (S_VBP),
    .SYNC_POL (1)
  ) dut_s (
    .clk_25 (clk_25),
    .reset  (reset),
    .bus    (bus_s)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  int unsigned pd = 0;  // pixel position in the standard frame
  int unsigned ps = 0;  // pixel position in the small frame

  logic [31:0] prev_d, prev_s;
  bit          have_prev = 1'b0;

  bit          counting = 1'b0;
  int unsigned cnt_hs = 0, cnt_von = 0, cnt_ls = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  // Packed layout: {7'b0, hsync, vsync, video_on, line_start, frame_start, row, col}
  function automatic logic [31:0] model(input int unsigned p, input bit rst, input bit pce,
                                        input int unsigned ha, input int unsigned hfp,
                                        input int unsigned hs, input int unsigned ht,
                                        input int unsigned va, input int unsigned vfp,
                                        input int unsigned vs, input bit pol);
    int unsigned col, row;
    logic hsy, vsy, von, ls, fs;
    if (rst) return {7'b0, ~pol, ~pol, 3'b000, 10'd0, 10'd0};
    col = p % ht;
    row = p / ht;
    hsy = (col >= ha + hfp && col < ha + hfp + hs) ? pol : ~pol;
    vsy = (row >= va + vfp && row < va + vfp + vs) ? pol : ~pol;
    von = (col < ha) && (row < va);
    ls  = pce && (col == 0);
    fs  = ls && (row == 0);
    return {7'b0, hsy, vsy, von, ls, fs, 10'(row), 10'(col)};
  endfunction

  function automatic logic [31:0] pack(input logic hsy, input logic vsy, input logic von,
                                       input logic ls, input logic fs,
                                       input logic [9:0] row, input logic [9:0] col);
    return {7'b0, hsy, vsy, von, ls, fs, row, col};
  endfunction

  task automatic step(input bit r, input bit c);
    logic [31:0] exp_d, exp_s, got_d, got_s, use_d;
    @(negedge clk_25);
    reset = r;
    ce    = c;
    #1;
    exp_d = model(pd, r, c, 640, 16, 96, D_HT, 480, 10, 2, 1'b0);
    exp_s = model(ps, r, c, S_HA, S_HFP, S_HS, S_HT, S_VA, S_VFP, S_VS, 1'b1);
    got_d = pack(bus_d.hsync, bus_d.vsync, bus_d.video_on, bus_d.line_start,
                 bus_d.frame_start, bus_d.s_pixel_row, bus_d.s_pixel_col);
    got_s = pack(bus_s.hsync, bus_s.vsync, bus_s.video_on, bus_s.line_start,
                 bus_s.frame_start, bus_s.s_pixel_row, bus_s.s_pixel_col);
`ifdef VGA_SYNC_REG_EN
    if (have_prev) begin
      check("std_raster", got_d, prev_d);
      check("small_raster", got_s, prev_s);
    end
    use_d     = have_prev ? got_d : exp_d;
    prev_d    = exp_d;
    prev_s    = exp_s;
    have_prev = 1'b1;
`else
    check("std_raster", got_d, exp_d);
    check("small_raster", got_s, exp_s);
    use_d = got_d;
`endif
    if (counting) begin
      if (use_d[24] == 1'b0) cnt_hs++;
      if (use_d[22]) cnt_von++;
      if (use_d[21]) cnt_ls++;
    end
    @(posedge clk_25);
    if (r) begin
      pd = 0;
      ps = 0;
    end else if (c) begin
      pd = (pd + 1) % (D_HT * D_VT);
      ps = (ps + 1) % (S_HT * S_VT);
    end
  endtask

  initial begin
    // Reset held for three clocks with pix_ce high.
    repeat (3) step(1'b1, 1'b1);

    // Two full standard lines: tally hsync, video_on and line_start.
    counting = 1'b1;
    repeat (2 * D_HT) step(1'b0, 1'b1);
    counting = 1'b0;
    check("hsync_clks_2lines", 32'(cnt_hs), 32'd192);
    check("video_on_clks_2lines", 32'(cnt_von), 32'd1280);
    check("line_start_2lines", 32'(cnt_ls), 32'd2);

    repeat (2000) step(1'b0, 1'b1);

    // Alternating enable: counters advance on every other clock.
    for (int i = 0; i < 3200; i++) step(1'b0, (i % 2) == 0);

    // Randomised enable with occasional single-clock resets.
    for (int i = 0; i < 30000; i++) begin
      step($urandom_range(0, 3999) == 0, $urandom_range(0, 3) != 0);
    end

    // Mid-frame single-clock reset, then clean running.
    step(1'b1, 1'b1);
    repeat (8000) step(1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
